// File: rtl/mult_seq_32.sv
// Sequential 32x32 signed radix-2 Booth multiplier with one iteration per clock.
// Optional overflow detection is enabled by defining MULT_EXCEPTION_EN.

module cla_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] gen_s;
  logic [31:0] prop_s;
  logic        carry_s;
  logic        c1_s;
  logic        c2_s;
  logic        c3_s;
  logic        grp_g_s;
  logic        grp_p_s;

  assign gen_s  = a & b;
  assign prop_s = a ^ b;

  // Four-bit lookahead groups chained through their group generate/propagate terms.
  always_comb begin
    sum     = 32'd0;
    carry_s = c_in;
    c1_s    = 1'b0;
    c2_s    = 1'b0;
    c3_s    = 1'b0;
    grp_g_s = 1'b0;
    grp_p_s = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c1_s = gen_s[4*k] | (prop_s[4*k] & carry_s);
      c2_s = gen_s[4*k+1] | (prop_s[4*k+1] & gen_s[4*k])
           | (prop_s[4*k+1] & prop_s[4*k] & carry_s);
      c3_s = gen_s[4*k+2] | (prop_s[4*k+2] & gen_s[4*k+1])
           | (prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k])
           | (prop_s[4*k+2] & prop_s[4*k+1] & prop_s[4*k] & carry_s);
      grp_g_s = gen_s[4*k+3] | (prop_s[4*k+3] & gen_s[4*k+2])
              | (prop_s[4*k+3] & prop_s[4*k+2] & gen_s[4*k+1])
              | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k]);
      grp_p_s = &prop_s[4*k +: 4];
      sum[4*k +: 4] = prop_s[4*k +: 4] ^ {c3_s, c2_s, c1_s, carry_s};
      carry_s = grp_g_s | (grp_p_s & carry_s);
    end
    c_out = carry_s;
  end
endmodule

module mult_seq_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_mult,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nxt_s;
  logic [64:0] prod_r;
  logic [31:0] a_r;
  logic [4:0]  cnt_r;
  logic [31:0] cla_y_s;
  logic        cla_cin_s;
  logic [31:0] cla_sum_s;
  logic        cla_cout_s;
  logic        sign_s;
  logic [64:0] prod_step_s;
  logic        exc_s;

  // Booth recoding of the low product pair selects +A, -A or nothing.
  always_comb begin
    cla_y_s   = 32'd0;
    cla_cin_s = 1'b0;
    case (prod_r[1:0])
      2'b01: begin
        cla_y_s   = a_r;
        cla_cin_s = 1'b0;
      end
      2'b10: begin
        cla_y_s   = ~a_r;
        cla_cin_s = 1'b1;
      end
      default: begin
        cla_y_s   = 32'd0;
        cla_cin_s = 1'b0;
      end
    endcase
  end

  cla_32 u_cla (
    .a     (prod_r[64:33]),
    .b     (cla_y_s),
    .c_in  (cla_cin_s),
    .sum   (cla_sum_s),
    .c_out (cla_cout_s)
  );

  // True 33-bit sign of the partial sum, so -(0x80000000) shifts in correctly.
  assign sign_s      = prod_r[64] ^ cla_y_s[31] ^ cla_cout_s;
  assign prod_step_s = {sign_s, cla_sum_s, prod_r[32:1]};

`ifdef MULT_EXCEPTION_EN
  function automatic logic overflow_f(input logic [32:0] hi);
    return !((&hi) || !(|hi));
  endfunction
  assign exc_s = overflow_f(prod_r[64:32]);
`else
  assign exc_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a start pulse in any state (re)starts an operation.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (ctrl_mult) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      RUN: begin
        if (ctrl_mult)              state_nxt_s = RUN;
        else if (cnt_r == 5'd31)    state_nxt_s = DONE;
        else                        state_nxt_s = RUN;
      end
      DONE: begin
        if (ctrl_mult) state_nxt_s = RUN;
        else           state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Operand latch, Booth iteration and saturating iteration counter.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prod_r <= 65'd0;
      a_r    <= 32'd0;
      cnt_r  <= 5'd0;
    end else if (ctrl_mult) begin
      prod_r <= {32'd0, data_operandB, 1'b0};
      a_r    <= data_operandA;
      cnt_r  <= 5'd0;
    end else if (state_r == RUN) begin
      prod_r <= prod_step_s;
      cnt_r  <= (cnt_r == 5'd31) ? cnt_r : cnt_r + 5'd1;
    end else begin
      prod_r <= prod_r;
      a_r    <= a_r;
      cnt_r  <= cnt_r;
    end
  end

  // Registered outputs, captured only when an operation completes.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      data_result    <= 32'd0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= (state_r == DONE);
      if (state_r == DONE) begin
        data_result    <= prod_r[32:1];
        data_exception <= exc_s;
      end else begin
        data_result    <= data_result;
        data_exception <= data_exception;
      end
    end
  end
endmodule

// File: tb/tb_mult_seq_32.sv
// Directed testbench for mult_seq_32; expected exception flags follow MULT_EXCEPTION_EN.

module tb_mult_seq_32;
  logic        clock;
  logic        reset;
  logic        ctrl_mult;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int tests_run;
  int tests_failed;

`ifdef MULT_EXCEPTION_EN
  localparam logic EXC_ON = 1'b1;
`else
  localparam logic EXC_ON = 1'b0;
`endif

  mult_seq_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_mult      (ctrl_mult),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Counts RDY pulses over max_cyc negedges; first is the 1-based cycle of the first pulse.
  task automatic wait_rdy(input int max_cyc, output int first, output int pulses,
                          output logic [31:0] res, output logic exc);
    first  = -1;
    pulses = 0;
    res    = 32'd0;
    exc    = 1'b0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clock);
      if (data_resultRDY === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = i;
          res   = data_result;
          exc   = data_exception;
        end
      end
    end
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult     = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_res, input logic exp_exc);
    int          first;
    int          pulses;
    logic [31:0] res;
    logic        exc;
    start_op(a, b);
    wait_rdy(40, first, pulses, res, exc);
    check({tag, "_lat"}, 32'(first), 32'd33);
    check({tag, "_pulses"}, 32'(pulses), 32'd1);
    check({tag, "_res"}, res, exp_res);
    check({tag, "_exc"}, {31'd0, exc}, {31'd0, exp_exc});
    check({tag, "_hold"}, data_result, exp_res);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          first;
    int          pulses;
    logic [31:0] res;
    logic        exc;
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    ctrl_mult     = 1'b0;
    data_operandA = 32'd3;
    data_operandB = 32'd5;

    repeat (2) @(negedge clock);
    check("rst_result", data_result, 32'd0);
    check("rst_exc", {31'd0, data_exception}, 32'd0);
    check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);

    ctrl_mult = 1'b1;
    repeat (3) @(negedge clock);
    ctrl_mult = 1'b0;
    reset     = 1'b0;
    wait_rdy(45, first, pulses, res, exc);
    check("ctrl_in_reset_pulses", 32'(pulses), 32'd0);

    run_op("m3x5", 32'd3, 32'd5, 32'h0000000F, 1'b0);
    run_op("mneg7x6", 32'hFFFFFFF9, 32'd6, 32'hFFFFFFD6, 1'b0);
    run_op("mmin_x_neg1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, EXC_ON);
    run_op("m2p16sq", 32'h00010000, 32'h00010000, 32'h00000000, EXC_ON);
    run_op("mneg1sq", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0);
    run_op("mmax_x2", 32'h7FFFFFFF, 32'd2, 32'hFFFFFFFE, EXC_ON);
    run_op("mminsq", 32'h80000000, 32'h80000000, 32'h00000000, EXC_ON);
    run_op("mx0", 32'h12345678, 32'd0, 32'h00000000, 1'b0);

    // Restart mid-RUN: only the second operation reports, 38 cycles after the first start.
    start_op(32'd3, 32'd5);
    repeat (3) @(negedge clock);
    data_operandA = 32'd4;
    data_operandB = 32'd4;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    wait_rdy(45, first, pulses, res, exc);
    check("abort_lat", 32'(first + 5), 32'd38);
    check("abort_pulses", 32'(pulses), 32'd1);
    check("abort_res", res, 32'h00000010);

    // Back-to-back: a start presented while in DONE still reports the finished result.
    start_op(32'd3, 32'd5);
    repeat (32) @(negedge clock);
    data_operandA = 32'hFFFFFFFF;
    data_operandB = 32'hFFFFFFFF;
    ctrl_mult     = 1'b1;
    @(negedge clock);
    ctrl_mult = 1'b0;
    check("b2b_first_rdy", {31'd0, data_resultRDY}, 32'd1);
    check("b2b_first_res", data_result, 32'h0000000F);
    wait_rdy(40, first, pulses, res, exc);
    check("b2b_second_lat", 32'(first), 32'd33);
    check("b2b_second_res", res, 32'h00000001);

    // Asynchronous reset mid-RUN clears outputs at once and drops the operation.
    start_op(32'd3, 32'd5);
    repeat (9) @(negedge clock);
    reset = 1'b1;
    #1;
    check("async_rst_result", data_result, 32'd0);
    check("async_rst_exc", {31'd0, data_exception}, 32'd0);
    check("async_rst_rdy", {31'd0, data_resultRDY}, 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    wait_rdy(40, first, pulses, res, exc);
    check("post_rst_pulses", 32'(pulses), 32'd0);
    check("post_rst_result", data_result, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/mult_seq_32.md
MULT_SEQ_32 -- requirements
Module: mult_seq_32

Interface
REQ-001 The block SHALL have no parameters; the datapath width is fixed at 32 bits.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-high; forces the IDLE state.
REQ-005 ctrl_mult  input  1  start pulse; sampled on the rising edge of clock.
REQ-006 data_operandA  input  32  multiplicand, two's complement.
REQ-007 data_operandB  input  32  multiplier, two's complement.
REQ-008 data_result  output  32  low 32 bits of the signed product.
REQ-009 data_exception  output  1  high when the signed product does not fit in 32 bits.
REQ-010 data_resultRDY  output  1  one-cycle pulse marking a valid data_result and data_exception.

Function
REQ-011 Algorithm: radix-2 Booth multiply using a single cla_32 instance as the only adder/subtractor (subtract = inverted operand plus c_in=1).
REQ-012 State machine: IDLE, RUN, DONE.
- IDLE -> RUN when ctrl_mult=1 at a clock edge.
- RUN -> DONE when the iteration counter reaches 31.
- DONE -> IDLE on the next edge; DONE -> RUN if ctrl_mult=1 at that edge.
REQ-013 On the start edge the block SHALL latch both operands.
- Working product register (65 bits) = {32'b0, B, 1'b0}.
- Iteration counter cleared to 0.
REQ-014 Each RUN cycle SHALL perform one iteration.
- Inspect product[1:0]: 01 adds A to the upper 32 bits; 10 subtracts A; 00/11 leave them unchanged.
- Then arithmetic-shift the 65-bit register right by 1.
- Increment the counter.
REQ-015 Latency: start edge at cycle N SHALL produce data_resultRDY=1 during cycle N+33 only.
REQ-016 data_result and data_exception SHALL be registered and SHALL hold their last value until the next DONE.
REQ-017 Exception: asserted when product bits [63:31] of the 64-bit result are not all equal.
REQ-018 ctrl_mult=1 while in RUN SHALL abort the current operation and restart with the newly presented operands; no RDY pulse is issued for the aborted operation.
REQ-019 Operands SHALL NOT be required to stay stable after the start edge.
REQ-020 The counter SHALL be 5 bits wide and SHALL NOT wrap inside a single operation.

Reset
REQ-021 reset=1 SHALL immediately, without a clock edge, force:
- state=IDLE, counter=0, product register=0;
- data_result=0, data_exception=0, data_resultRDY=0.
REQ-022 Reset asserted mid-RUN SHALL discard the operation; no data_resultRDY pulse follows its deassertion.
REQ-023 ctrl_mult asserted while reset=1 SHALL be ignored.

Configuration
REQ-024 Macro MULT_EXCEPTION_EN controls overflow detection.
- Defined: data_exception behaves per REQ-017.
- Undefined: data_exception is tied to 0, with no detection logic synthesized; all other behaviour is unchanged.

Verification
REQ-025 A=3, B=5, ctrl_mult pulsed at cycle 0 -> data_resultRDY=1 at cycle 33 only, data_result=0x0000000F, data_exception=0.
REQ-026 A=-7, B=6 -> data_result=0xFFFFFFD6, data_exception=0.
REQ-027 A=0x80000000, B=0xFFFFFFFF -> data_result=0x80000000, data_exception=1 (0 when MULT_EXCEPTION_EN undefined).
REQ-028 A=0x00010000, B=0x00010000 -> data_result=0x00000000, data_exception=1.
REQ-029 Start 3*5, assert reset at cycle 10 and release at cycle 12 -> all outputs 0 from cycle 10, and no RDY pulse through cycle 50.
REQ-030 Start 3*5 at cycle 0, start 4*4 at cycle 5 -> single RDY pulse at cycle 38 with data_result=0x00000010.
